// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared types for the I/D memory port arbiter
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

  typedef enum logic {
    PORT_I = 1'b0,
    PORT_D = 1'b1
  } port_t;

endpackage

// File: rtl/mem_arb_sel.sv
// rtl/mem_arb_sel.sv - combinational winner pick between fetch and data requests
module mem_arb_sel
  import mem_arb_pkg::*;
#(
  parameter int D_PRIORITY = 1
) (
  input  logic i_req,
  input  logic d_req,
  input  logic last_is_d,
  output logic any,
  output logic pick_d
);

  // D wins alone; on a tie D wins outright or the port not served last time wins
  always_comb begin
    any    = i_req | d_req;
    pick_d = 1'b0;
    if (d_req && !i_req) begin
      pick_d = 1'b1;
    end else if (d_req && i_req) begin
      pick_d = (D_PRIORITY != 0) ? 1'b1 : ~last_is_d;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - shares one memory port between CPU fetch and data ports
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int D_PRIORITY = 1,
  parameter int TIMEOUT    = 64,
  parameter int CNT_W      = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              i_req_i,
  input  logic [ADDR_W-1:0] i_addr_i,
  output logic              i_ready_o,
  output logic [DATA_W-1:0] i_rdata_o,
  input  logic              d_req_i,
  input  logic              d_we_i,
  input  logic [ADDR_W-1:0] d_addr_i,
  input  logic [DATA_W-1:0] d_wdata_i,
  output logic              d_ready_o,
  output logic [DATA_W-1:0] d_rdata_o,
  output logic              err_o,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic              mem_ack_i,
  input  logic [DATA_W-1:0] mem_rdata_i,
  output logic [CNT_W-1:0]  i_cnt_o,
  output logic [CNT_W-1:0]  d_cnt_o
);

  // wide enough to hold TIMEOUT-1; one bit minimum when the watchdog is off
  localparam int WD_W = $clog2(TIMEOUT + 2);

  state_t          state;
  state_t          state_nx;
  port_t           winner;
  port_t           last_grant;
  logic            timed_out;
  logic [WD_W-1:0] wd_cnt;
  logic            expire;
  logic            sel_any;
  logic            sel_d;

  mem_arb_sel #(
    .D_PRIORITY(D_PRIORITY)
  ) u_sel (
    .i_req    (i_req_i),
    .d_req    (d_req_i),
    .last_is_d(last_grant == PORT_D),
    .any      (sel_any),
    .pick_d   (sel_d)
  );

  // next state, watchdog expiry and the per-port completion strobes
  always_comb begin
    state_nx  = state;
    expire    = 1'b0;
    i_ready_o = 1'b0;
    d_ready_o = 1'b0;
    err_o     = 1'b0;
    if (TIMEOUT != 0) begin
      expire = (wd_cnt == WD_W'(TIMEOUT - 1));
    end
    case (state)
      IDLE: begin
        if (sel_any) state_nx = BUSY;
      end
      BUSY: begin
        if (mem_ack_i || expire) state_nx = RESP;
      end
      RESP: begin
        state_nx  = IDLE;
        i_ready_o = (winner == PORT_I);
        d_ready_o = (winner == PORT_D);
        err_o     = timed_out;
      end
      default: state_nx = IDLE;
    endcase
  end

  // state register, grant latch, memory request registers and watchdog
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state       <= IDLE;
      winner      <= PORT_I;
      last_grant  <= PORT_D;
      timed_out   <= 1'b0;
      wd_cnt      <= '0;
      mem_req_o   <= 1'b0;
      mem_we_o    <= 1'b0;
      mem_addr_o  <= '0;
      mem_wdata_o <= '0;
    end else begin
      state <= state_nx;
      case (state)
        IDLE: begin
          if (sel_any) begin
            winner      <= sel_d ? PORT_D : PORT_I;
            mem_req_o   <= 1'b1;
            mem_we_o    <= sel_d & d_we_i;
            mem_addr_o  <= sel_d ? d_addr_i : i_addr_i;
            mem_wdata_o <= sel_d ? d_wdata_i : '0;
            wd_cnt      <= '0;
            timed_out   <= 1'b0;
          end
        end
        BUSY: begin
          // an ack on the expiry cycle still completes normally
          if (mem_ack_i) begin
            mem_req_o <= 1'b0;
          end else if (expire) begin
            mem_req_o <= 1'b0;
            timed_out <= 1'b1;
          end else begin
            wd_cnt <= wd_cnt + 1'b1;
          end
        end
        RESP: begin
          last_grant <= winner;
        end
        default: ;
      endcase
    end
  end

  // read data capture and saturating completion counters, updated only on ack
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      i_rdata_o <= '0;
      d_rdata_o <= '0;
      i_cnt_o   <= '0;
      d_cnt_o   <= '0;
    end else if (state == BUSY && mem_ack_i) begin
      if (winner == PORT_I) begin
        i_rdata_o <= mem_rdata_i;
        if (i_cnt_o != {CNT_W{1'b1}}) i_cnt_o <= i_cnt_o + 1'b1;
      end else begin
        if (!mem_we_o) d_rdata_o <= mem_rdata_i;
        if (d_cnt_o != {CNT_W{1'b1}}) d_cnt_o <= d_cnt_o + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - randomized transaction-level check of mem_port_arbiter
module tb_mem_port_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 4;
  localparam int CW = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // index 0: round-robin instance, index 1: D-priority instance
  logic          i_req     [2];
  logic [AW-1:0] i_addr    [2];
  logic          i_ready   [2];
  logic [DW-1:0] i_rdata   [2];
  logic          d_req     [2];
  logic          d_we      [2];
  logic [AW-1:0] d_addr    [2];
  logic [DW-1:0] d_wdata   [2];
  logic          d_ready   [2];
  logic [DW-1:0] d_rdata   [2];
  logic          err       [2];
  logic          mem_req   [2];
  logic          mem_we    [2];
  logic [AW-1:0] mem_addr  [2];
  logic [DW-1:0] mem_wdata [2];
  logic          mem_ack   [2];
  logic [DW-1:0] mem_rdata [2];
  logic [CW-1:0] i_cnt     [2];
  logic [CW-1:0] d_cnt     [2];

  mem_port_arbiter #(
    .ADDR_W(AW), .DATA_W(DW), .D_PRIORITY(0), .TIMEOUT(TO), .CNT_W(CW)
  ) u_rr (
    .clk_i(clk), .rst_i(rst),
    .i_req_i(i_req[0]), .i_addr_i(i_addr[0]), .i_ready_o(i_ready[0]), .i_rdata_o(i_rdata[0]),
    .d_req_i(d_req[0]), .d_we_i(d_we[0]), .d_addr_i(d_addr[0]), .d_wdata_i(d_wdata[0]),
    .d_ready_o(d_ready[0]), .d_rdata_o(d_rdata[0]), .err_o(err[0]),
    .mem_req_o(mem_req[0]), .mem_we_o(mem_we[0]), .mem_addr_o(mem_addr[0]),
    .mem_wdata_o(mem_wdata[0]), .mem_ack_i(mem_ack[0]), .mem_rdata_i(mem_rdata[0]),
    .i_cnt_o(i_cnt[0]), .d_cnt_o(d_cnt[0])
  );

  mem_port_arbiter #(
    .ADDR_W(AW), .DATA_W(DW), .D_PRIORITY(1), .TIMEOUT(TO), .CNT_W(CW)
  ) u_dp (
    .clk_i(clk), .rst_i(rst),
    .i_req_i(i_req[1]), .i_addr_i(i_addr[1]), .i_ready_o(i_ready[1]), .i_rdata_o(i_rdata[1]),
    .d_req_i(d_req[1]), .d_we_i(d_we[1]), .d_addr_i(d_addr[1]), .d_wdata_i(d_wdata[1]),
    .d_ready_o(d_ready[1]), .d_rdata_o(d_rdata[1]), .err_o(err[1]),
    .mem_req_o(mem_req[1]), .mem_we_o(mem_we[1]), .mem_addr_o(mem_addr[1]),
    .mem_wdata_o(mem_wdata[1]), .mem_ack_i(mem_ack[1]), .mem_rdata_i(mem_rdata[1]),
    .i_cnt_o(i_cnt[1]), .d_cnt_o(d_cnt[1])
  );

  int total = 0;
  int bad   = 0;

  // reference model: what each instance should expose between accesses
  logic          m_last_d [2];
  logic [CW-1:0] m_icnt   [2];
  logic [CW-1:0] m_dcnt   [2];
  logic [DW-1:0] m_irdata [2];
  logic [DW-1:0] m_drdata [2];
  logic          pend_i   [2];
  logic          pend_d   [2];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_last_d[k] = 1'b1;
      m_icnt[k]   = '0;
      m_dcnt[k]   = '0;
      m_irdata[k] = '0;
      m_drdata[k] = '0;
      pend_i[k]   = 1'b0;
      pend_d[k]   = 1'b0;
    end
  endtask

  task automatic check_idle(input int k, input string pfx);
    check({pfx, ".i_ready"}, i_ready[k], 1'b0);
    check({pfx, ".d_ready"}, d_ready[k], 1'b0);
    check({pfx, ".err"}, err[k], 1'b0);
    check({pfx, ".mem_req"}, mem_req[k], 1'b0);
    check({pfx, ".i_rdata"}, i_rdata[k], m_irdata[k]);
    check({pfx, ".d_rdata"}, d_rdata[k], m_drdata[k]);
    check({pfx, ".i_cnt"}, i_cnt[k], m_icnt[k]);
    check({pfx, ".d_cnt"}, d_cnt[k], m_dcnt[k]);
  endtask

  task automatic set_i(input int k);
    i_addr[k] = $urandom;
    i_req[k]  = 1'b1;
    pend_i[k] = 1'b1;
  endtask

  task automatic set_d(input int k);
    d_addr[k]  = $urandom;
    d_we[k]    = 1'($urandom_range(0, 1));
    d_wdata[k] = $urandom;
    d_req[k]   = 1'b1;
    pend_d[k]  = 1'b1;
  endtask

  // one granted access, entered on a negedge with the arbiter idle
  task automatic serve_one(input int k, input bit reissue);
    logic          w_d;
    logic          to;
    int            n;
    int            del;
    logic [DW-1:0] rd;
    logic [AW-1:0] a;
    string         pfx;
    pfx = (k == 0) ? "rr" : "dp";
    if (pend_i[k] && pend_d[k]) w_d = (k == 1) ? 1'b1 : ~m_last_d[k];
    else                        w_d = pend_d[k];
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!mem_req[k] && n < 8);
    check({pfx, ".grant_lat"}, n, 1);
    if (!mem_req[k]) begin
      pend_i[k] = 1'b0;
      pend_d[k] = 1'b0;
      i_req[k]  = 1'b0;
      d_req[k]  = 1'b0;
      return;
    end
    a = w_d ? d_addr[k] : i_addr[k];
    check({pfx, ".mem_addr"}, mem_addr[k], a);
    check({pfx, ".mem_we"}, mem_we[k], w_d ? d_we[k] : 1'b0);
    if (w_d) check({pfx, ".mem_wdata"}, mem_wdata[k], d_wdata[k]);
    // a requester losing interest mid-access must still see its ready pulse
    if ($urandom_range(0, 3) == 0) begin
      if (w_d) d_req[k] = 1'b0;
      else     i_req[k] = 1'b0;
    end
    del = $urandom_range(0, TO);
    to  = (del == TO);
    rd  = $urandom;
    for (int j = 0; j < TO; j++) begin
      check({pfx, ".mem_req_hold"}, mem_req[k], 1'b1);
      check({pfx, ".mem_addr_hold"}, mem_addr[k], a);
      if (j == del) begin
        mem_ack[k]   = 1'b1;
        mem_rdata[k] = rd;
        @(negedge clk);
        mem_ack[k]   = 1'b0;
        mem_rdata[k] = $urandom;
        break;
      end
      @(negedge clk);
    end
    check({pfx, ".win_ready"}, w_d ? d_ready[k] : i_ready[k], 1'b1);
    check({pfx, ".other_ready"}, w_d ? i_ready[k] : d_ready[k], 1'b0);
    check({pfx, ".err"}, err[k], to);
    check({pfx, ".mem_req_drop"}, mem_req[k], 1'b0);
    if (!to) begin
      if (w_d) begin
        if (!d_we[k]) m_drdata[k] = rd;
        if (m_dcnt[k] != {CW{1'b1}}) m_dcnt[k] = m_dcnt[k] + 1'b1;
      end else begin
        m_irdata[k] = rd;
        if (m_icnt[k] != {CW{1'b1}}) m_icnt[k] = m_icnt[k] + 1'b1;
      end
    end
    m_last_d[k] = w_d;
    if (reissue) begin
      if (w_d) set_d(k);
      else     set_i(k);
    end else if (w_d) begin
      d_req[k]  = 1'b0;
      pend_d[k] = 1'b0;
    end else begin
      i_req[k]  = 1'b0;
      pend_i[k] = 1'b0;
    end
    @(negedge clk);
    check_idle(k, {pfx, ".post"});
  endtask

  task automatic do_round(input int k, input bit wi, input bit wd, input int extra);
    int ex;
    ex = extra;
    if (wi) set_i(k);
    if (wd) set_d(k);
    while (pend_i[k] || pend_d[k]) begin
      serve_one(k, ex > 0);
      if (ex > 0) ex--;
    end
  endtask

  initial begin
    int pat;
    rst = 1'b1;
    for (int k = 0; k < 2; k++) begin
      i_req[k] = 1'b0; i_addr[k] = '0; d_req[k] = 1'b0; d_we[k] = 1'b0;
      d_addr[k] = '0; d_wdata[k] = '0; mem_ack[k] = 1'b0; mem_rdata[k] = '0;
    end
    model_reset();
    repeat (3) @(negedge clk);
    check_idle(0, "rst.rr");
    check_idle(1, "rst.dp");
    rst = 1'b0;
    @(negedge clk);

    // continuous requests on both ports: alternation vs D always first
    do_round(0, 1'b1, 1'b1, 3);
    do_round(1, 1'b1, 1'b1, 3);

    for (int r = 0; r < 50; r++) begin
      for (int k = 0; k < 2; k++) begin
        pat = $urandom_range(1, 3);
        do_round(k, pat[0], pat[1], $urandom_range(0, 2));
      end
    end

    // reset while an access is in flight
    set_i(0);
    @(negedge clk);
    check("mid.mem_req_up", mem_req[0], 1'b1);
    #2 rst = 1'b1;
    #1;
    model_reset();
    i_req[0] = 1'b0;
    check("mid.mem_req", mem_req[0], 1'b0);
    check("mid.mem_addr", mem_addr[0], '0);
    check("mid.i_cnt", i_cnt[0], '0);
    check("mid.d_cnt", d_cnt[0], '0);
    check("mid.i_rdata", i_rdata[0], '0);
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      check("mid.no_ready", i_ready[0] | d_ready[0], 1'b0);
    end
    do_round(0, 1'b1, 1'b0, 0);
    do_round(0, 1'b1, 1'b1, 1);
    do_round(1, 1'b0, 1'b1, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
